// File: rtl/ln_bert_pkg.sv
// Shared constants for the BERT LayerNorm affine stage: default geometry,
// Q4.12 constants and saturation-limit helpers.
package ln_bert_pkg;

    localparam int N_CH_DEF = 64;
    localparam int DW_DEF   = 16;
    localparam int FRAC_DEF = 12;
    localparam int BANK_DEF = 12;
    localparam int ADDR_W   = 6;

    localparam logic [DW_DEF-1:0] Q_ONE   = 16'h1000;
    localparam logic [DW_DEF-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [DW_DEF-1:0] SAT_MIN = 16'h8000;

    function automatic longint sat_hi(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_lo(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ln_affine_lane.sv
// One channel of the affine stage: S2 multiply+round, S3 add beta+saturate.
module ln_affine_lane
    import ln_bert_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic signed [DW-1:0] i_x,
    input  logic signed [DW-1:0] i_gamma,
    input  logic signed [DW-1:0] i_beta,
    output logic signed [DW-1:0] o_y
);

    localparam int PW = 2 * DW;
    localparam logic signed [PW-1:0]   RND  = PW'(64'sd1 <<< (FRAC - 1));
    localparam logic signed [PW-1:0]   P_HI = PW'(sat_hi(DW + 1));
    localparam logic signed [PW-1:0]   P_LO = PW'(sat_lo(DW + 1));
    localparam logic signed [DW+1:0]   Y_HI = (DW + 2)'(sat_hi(DW));
    localparam logic signed [DW+1:0]   Y_LO = (DW + 2)'(sat_lo(DW));

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] rnd;
    logic signed [DW:0]   s2_p_d, s2_p_q;
    logic signed [DW-1:0] s2_b_q;
    logic signed [DW+1:0] sum;
    logic signed [DW-1:0] y_d, y_q;

    // The rounded product is pre-clamped to DW+1 bits; anything beyond that
    // saturates the final result regardless of beta, so the DW+2 sum stays exact.
    always_comb begin
        prod   = PW'(i_x) * PW'(i_gamma);
        rnd    = (prod + RND) >>> FRAC;
        s2_p_d = (rnd > P_HI) ? P_HI[DW:0] : ((rnd < P_LO) ? P_LO[DW:0] : rnd[DW:0]);
        sum    = (DW + 2)'(s2_p_q) + (DW + 2)'(s2_b_q);
        y_d    = (sum > Y_HI) ? Y_HI[DW-1:0] : ((sum < Y_LO) ? Y_LO[DW-1:0] : sum[DW-1:0]);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s2_p_q <= '0;
            s2_b_q <= '0;
            y_q    <= '0;
        end else if (i_en) begin
            s2_p_q <= s2_p_d;
            s2_b_q <= i_beta;
            y_q    <= y_d;
        end
    end

    assign o_y = y_q;

endmodule

// File: rtl/ln_bert_affine_stage.sv
// LayerNorm affine stage (y = x*gamma + beta) over N_CH lanes with a 3-stage
// pipeline, per-channel gamma/beta storage and bank-boundary marking.
module ln_bert_affine_stage
    import ln_bert_pkg::*;
#(
    parameter int N_CH = N_CH_DEF,
    parameter int DW   = DW_DEF,
    parameter int FRAC = FRAC_DEF,
    parameter int BANK = BANK_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic                 i_valid,
    input  logic [N_CH*DW-1:0]   i_data_flat,
    input  logic                 i_param_we,
    input  logic [ADDR_W-1:0]    i_param_addr,
    input  logic [DW-1:0]        i_gamma,
    input  logic [DW-1:0]        i_beta,
    output logic [N_CH*DW-1:0]   o_result_flat,
    output logic                 o_valid,
    output logic                 o_last
);

    localparam int            CW       = cnt_w(BANK);
    localparam logic [DW-1:0] G_ONE    = DW'(64'sd1 <<< FRAC);
    localparam logic [CW-1:0] CNT_LAST = CW'(BANK - 1);

    logic [DW-1:0] gamma_q [N_CH];
    logic [DW-1:0] beta_q  [N_CH];
    logic [DW-1:0] x1_q    [N_CH];
    logic [DW-1:0] g1_q    [N_CH];
    logic [DW-1:0] b1_q    [N_CH];
    logic          v1_q, v2_q, v3_q;
    logic          last_d, last_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic          addr_ok;

    assign addr_ok = 32'(i_param_addr) < N_CH;

    // Parameter writes ignore i_en so software can reprogram a stalled pipe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int c = 0; c < N_CH; c++) begin
                gamma_q[c] <= G_ONE;
                beta_q[c]  <= '0;
            end
        end else if (i_param_we && addr_ok) begin
            gamma_q[i_param_addr] <= i_gamma;
            beta_q[i_param_addr]  <= i_beta;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            last_q <= 1'b0;
            cnt_q  <= '0;
            for (int c = 0; c < N_CH; c++) begin
                x1_q[c] <= '0;
                g1_q[c] <= '0;
                b1_q[c] <= '0;
            end
        end else if (i_en) begin
            v1_q   <= i_valid;
            v2_q   <= v1_q;
            v3_q   <= v2_q;
            last_q <= last_d;
            cnt_q  <= cnt_d;
            for (int c = 0; c < N_CH; c++) begin
                x1_q[c] <= i_data_flat[DW*c +: DW];
                g1_q[c] <= gamma_q[c];
                b1_q[c] <= beta_q[c];
            end
        end
    end

    // Counter tracks the packet entering the output register.
    always_comb begin
        cnt_d  = cnt_q;
        last_d = 1'b0;
        if (v2_q) begin
            last_d = (cnt_q == CNT_LAST);
            cnt_d  = last_d ? '0 : cnt_q + 1'b1;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_lane
        ln_affine_lane #(
            .DW   (DW),
            .FRAC (FRAC)
        ) u_lane (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_en    (i_en),
            .i_x     (x1_q[c]),
            .i_gamma (g1_q[c]),
            .i_beta  (b1_q[c]),
            .o_y     (o_result_flat[DW*c +: DW])
        );
    end

    assign o_valid = v3_q;
    assign o_last  = last_q;

endmodule

// File: tb/tb_ln_bert_affine_stage.sv
// Directed bench for ln_bert_affine_stage: hand-computed vector table plus
// stream sequences (throughput, stall, mid-stream reset) against a lane model.
module tb_ln_bert_affine_stage;

    localparam int N_CH = 64;
    localparam int DW   = 16;
    localparam int BANK = 12;
    localparam int FW   = N_CH * DW;
    localparam int CKW  = FW + 2;

    logic            i_clk = 1'b0;
    logic            i_rst, i_en, i_valid, i_param_we;
    logic [FW-1:0]   i_data_flat;
    logic [5:0]      i_param_addr;
    logic [DW-1:0]   i_gamma, i_beta;
    logic [FW-1:0]   o_result_flat;
    logic            o_valid, o_last;

    always #5 i_clk = ~i_clk;

    ln_bert_affine_stage dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_en          (i_en),
        .i_valid       (i_valid),
        .i_data_flat   (i_data_flat),
        .i_param_we    (i_param_we),
        .i_param_addr  (i_param_addr),
        .i_gamma       (i_gamma),
        .i_beta        (i_beta),
        .o_result_flat (o_result_flat),
        .o_valid       (o_valid),
        .o_last        (o_last)
    );

    typedef struct {
        logic [15:0] x;
        logic [15:0] g;
        logic [15:0] b;
        logic [15:0] y;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0]  g_m [N_CH];
    logic [DW-1:0]  b_m [N_CH];
    logic [FW-1:0]  exp_q [$];
    logic [CKW-1:0] prev_res;
    int out_idx, n_out, n_last, first_cyc, last_cyc, cyc;

    task automatic chk(input string name, input logic [CKW-1:0] act, input logic [CKW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] affine(input logic [DW-1:0] x, input logic [DW-1:0] g,
                                             input logic [DW-1:0] b);
        longint p, r, s;
        p = longint'($signed(x)) * longint'($signed(g));
        r = (p + 2048) >>> 12;
        s = r + longint'($signed(b));
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        return s[DW-1:0];
    endfunction

    function automatic logic [FW-1:0] model(input logic [FW-1:0] x);
        logic [FW-1:0] r;
        for (int c = 0; c < N_CH; c++) r[DW*c +: DW] = affine(x[DW*c +: DW], g_m[c], b_m[c]);
        return r;
    endfunction

    function automatic logic [FW-1:0] pkt(input int id);
        logic [FW-1:0] r;
        int v;
        for (int c = 0; c < N_CH; c++) begin
            v = id * 1237 + c * 4099 + 53;
            r[DW*c +: DW] = v[15:0];
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            g_m[c] = 16'h1000;
            b_m[c] = 16'h0000;
        end
    endtask

    // One clock: drive, advance, then check the sampled outputs against the queue.
    task automatic step(input logic en, input logic vld, input logic rst, input logic [FW-1:0] data);
        i_en = en; i_valid = vld; i_rst = rst; i_data_flat = data;
        @(posedge i_clk); #1;
        cyc++;
        if (rst) begin
            exp_q.delete();
            out_idx = 0;
            model_reset();
        end else begin
            if (en && vld) exp_q.push_back(model(data));
            if (o_last && !o_valid) chk("last_without_valid", CKW'(o_last), '0);
            if (en && o_valid) begin
                if (n_out == 0) first_cyc = cyc;
                last_cyc = cyc;
                n_out++;
                if (o_last) n_last++;
                if (exp_q.size() == 0) chk("unexpected_valid", CKW'(o_valid), '0);
                else begin
                    chk("stream_data", CKW'(o_result_flat), CKW'(exp_q.pop_front()));
                    chk("stream_last", CKW'(o_last), CKW'((out_idx % BANK) == BANK - 1));
                end
                out_idx++;
            end
            if (!en) chk("stall_hold", {o_valid, o_last, o_result_flat}, prev_res);
        end
        prev_res = {o_valid, o_last, o_result_flat};
        i_rst = 1'b0;
        i_valid = 1'b0;
    endtask

    task automatic write_param(input int a, input logic [DW-1:0] g, input logic [DW-1:0] b);
        i_param_we = 1'b1; i_param_addr = 6'(a); i_gamma = g; i_beta = b;
        step(1'b1, 1'b0, 1'b0, '0);
        i_param_we = 1'b0;
        g_m[a] = g;
        b_m[a] = b;
    endtask

    task automatic clear_stats();
        n_out = 0; n_last = 0; first_cyc = -1; last_cyc = -1;
    endtask

    vec_t vt [14];

    initial begin
        vt[0]  = '{16'h0C00, 16'h2000, 16'h0800, 16'h2000};
        vt[1]  = '{16'hF000, 16'h2000, 16'h0800, 16'hE800};
        vt[2]  = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        vt[3]  = '{16'h8000, 16'h7FFF, 16'h8000, 16'h8000};
        vt[4]  = '{16'h0001, 16'h07FF, 16'h0000, 16'h0000};
        vt[5]  = '{16'h0002, 16'h0800, 16'h0000, 16'h0001};
        vt[6]  = '{16'h0003, 16'h0800, 16'h0000, 16'h0002};
        vt[7]  = '{16'hFFFF, 16'h0800, 16'h0000, 16'h0000};
        vt[8]  = '{16'hFFFD, 16'h0800, 16'h0000, 16'hFFFF};
        vt[9]  = '{16'h4000, 16'h1000, 16'h3FFE, 16'h7FFE};
        vt[10] = '{16'hC000, 16'h1000, 16'hC001, 16'h8001};
        vt[11] = '{16'h7FFF, 16'h2000, 16'h8000, 16'h7FFE};
        vt[12] = '{16'h4000, 16'h1000, 16'h4000, 16'h7FFF};
        vt[13] = '{16'hC000, 16'h1000, 16'hBFFF, 16'h8000};

        i_rst = 1'b1; i_en = 1'b0; i_valid = 1'b0; i_param_we = 1'b0;
        i_param_addr = '0; i_gamma = '0; i_beta = '0; i_data_flat = '0;
        cyc = 0; out_idx = 0; prev_res = '0;
        model_reset();
        clear_stats();

        step(1'b0, 1'b0, 1'b1, '0);
        step(1'b0, 1'b0, 1'b1, '0);
        chk("rst_valid", CKW'(o_valid), '0);
        chk("rst_last", CKW'(o_last), '0);
        chk("rst_result", CKW'(o_result_flat), '0);

        // Default params: x=1.0 on every lane comes back unchanged, 3 edges later.
        begin
            int lat;
            step(1'b1, 1'b1, 1'b0, {N_CH{16'h1000}});
            lat = 1;
            chk("valid_early", CKW'(o_valid), '0);
            while (!o_valid && lat < 10) begin
                step(1'b1, 1'b0, 1'b0, '0);
                lat++;
            end
            chk("latency", CKW'(lat), CKW'(3));
            chk("rst_default_lanes", CKW'(o_result_flat), CKW'({N_CH{16'h1000}}));
            step(1'b1, 1'b0, 1'b0, '0);
            chk("valid_one_cycle", CKW'(o_valid), '0);
        end

        for (int i = 0; i < 14; i++) begin
            int k, kn;
            k  = (i * 7) % N_CH;
            kn = (k + 1) % N_CH;
            write_param(k, vt[i].g, vt[i].b);
            step(1'b1, 1'b1, 1'b0, {N_CH{vt[i].x}});
            step(1'b1, 1'b0, 1'b0, '0);
            step(1'b1, 1'b0, 1'b0, '0);
            chk("vec_valid", CKW'(o_valid), CKW'(1'b1));
            chk($sformatf("vec%0d_lane%0d", i, k), CKW'(o_result_flat[DW*k +: DW]), CKW'(vt[i].y));
            chk($sformatf("vec%0d_idle_lane%0d", i, kn), CKW'(o_result_flat[DW*kn +: DW]), CKW'(vt[i].x));
            write_param(k, 16'h1000, 16'h0000);
        end

        // Write on the accept edge: packet A keeps old gamma, packet B sees the new one.
        i_param_we = 1'b1; i_param_addr = 6'd3; i_gamma = 16'h2000; i_beta = 16'h0000;
        step(1'b1, 1'b1, 1'b0, {N_CH{16'h0400}});
        i_param_we = 1'b0;
        g_m[3] = 16'h2000;
        step(1'b1, 1'b1, 1'b0, {N_CH{16'h0400}});
        step(1'b1, 1'b0, 1'b0, '0);
        chk("write_edge_old", CKW'(o_result_flat[DW*3 +: DW]), CKW'(16'h0400));
        step(1'b1, 1'b0, 1'b0, '0);
        chk("write_edge_new", CKW'(o_result_flat[DW*3 +: DW]), CKW'(16'h0800));
        write_param(3, 16'h1000, 16'h0000);

        // Reset beats a same-edge parameter write, even with i_en low.
        i_param_we = 1'b1; i_param_addr = 6'd0; i_gamma = 16'h3000; i_beta = 16'h0100;
        step(1'b0, 1'b1, 1'b1, {N_CH{16'h0800}});
        i_param_we = 1'b0;
        step(1'b1, 1'b1, 1'b0, {N_CH{16'h0800}});
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        chk("rst_prio_lane0", CKW'(o_result_flat[15:0]), CKW'(16'h0800));

        // 120 back-to-back packets: 10 banks, no bubbles.
        step(1'b1, 1'b0, 1'b1, '0);
        write_param(0, 16'h1800, 16'h0100);
        write_param(9, 16'hF000, 16'h0000);
        clear_stats();
        for (int p = 0; p < 120; p++) step(1'b1, 1'b1, 1'b0, pkt(p));
        for (int t = 0; t < 4; t++) step(1'b1, 1'b0, 1'b0, '0);
        chk("tput_count", CKW'(n_out), CKW'(120));
        chk("tput_span", CKW'(last_cyc - first_cyc), CKW'(119));
        chk("tput_last_pulses", CKW'(n_last), CKW'(10));

        // Five-cycle stall with i_valid held high while the pipe is full.
        step(1'b1, 1'b0, 1'b1, '0);
        write_param(5, 16'h0C00, 16'hFF00);
        clear_stats();
        begin
            int p;
            p = 0;
            for (int t = 0; t < 50; t++) begin
                logic en;
                en = !(t >= 10 && t < 15);
                step(en, p < 30, 1'b0, pkt(1000 + p));
                if (en && p < 30) p++;
            end
        end
        chk("stall_count", CKW'(n_out), CKW'(30));

        // Reset after 7 accepted packets: in-flight ones vanish, bank restarts.
        step(1'b1, 1'b0, 1'b1, '0);
        for (int p = 0; p < 7; p++) step(1'b1, 1'b1, 1'b0, pkt(2000 + p));
        step(1'b1, 1'b0, 1'b1, '0);
        for (int t = 0; t < 4; t++) begin
            step(1'b1, 1'b0, 1'b0, '0);
            chk("post_rst_valid", CKW'(o_valid), '0);
        end
        clear_stats();
        for (int p = 0; p < 12; p++) step(1'b1, 1'b1, 1'b0, pkt(3000 + p));
        for (int t = 0; t < 4; t++) step(1'b1, 1'b0, 1'b0, '0);
        chk("post_rst_count", CKW'(n_out), CKW'(12));
        chk("post_rst_last", CKW'(n_last), CKW'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
